// File: rtl/debounced_input_interface.sv
// Memory-mapped SW/KEY peripheral: per-input sync + debounce, STATE/EDGE/MASK/COUNT
// registers on the core data bus, level irq on any unmasked rising edge.

module debounced_input_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic core_clock,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_level;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_done;

  assign w_diff = r_s2 ^ r_level;
  assign w_done = w_diff && (r_cnt == CNT_LAST);

  // Any agreement between s2 and the level restarts the stability window.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_diff || w_done) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      if (w_done) r_level <= r_s2;
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_done & r_s2;
endmodule

module debounced_input_interface #(
  parameter logic [31:0]           BASE_ADDRESS    = 32'hFF20_0300,
  parameter int unsigned           NUM_INPUTS      = 14,
  parameter logic [NUM_INPUTS-1:0] INVERT_MASK     = 14'h3C00,
  parameter int unsigned           DEBOUNCE_CYCLES = 50000
) (
  input  logic                  core_clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] raw_inputs,
  input  logic                  wReadEnable,
  input  logic                  wWriteEnable,
  input  logic [3:0]            wByteEnable,
  input  logic [31:0]           wAddress,
  input  logic [31:0]           wWriteData,
  inout  wire  [31:0]           wReadData,
  output logic                  irq
);
  localparam int unsigned NI = NUM_INPUTS;
  localparam logic [1:0] OFS_STATE = 2'd0;
  localparam logic [1:0] OFS_EDGE  = 2'd1;
  localparam logic [1:0] OFS_MASK  = 2'd2;
  localparam logic [1:0] OFS_COUNT = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  ofs;
    logic [31:0] bmask;
    logic [31:0] data;
  } bus_wr_t;

  logic [NI-1:0] w_raw, w_level, w_rise;
  logic [NI-1:0] w_edge_clr, w_lane_mask;
  logic [NI-1:0] r_edge, r_mask;
  logic [31:0]   r_count;
  logic [31:0]   w_bmask, w_rdata;
  logic          w_sel, w_any_rise, w_mask_we, w_cnt_clr, w_unused;
  bus_wr_t       w_wr;

  // Inversion ahead of the synchronisers keeps idle active-low KEYs at 0 out of reset.
  assign w_raw = raw_inputs ^ INVERT_MASK;

  debounced_input_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NI-1:0] (
    .core_clock (core_clock),
    .reset_n    (reset_n),
    .i_raw      (w_raw),
    .o_level    (w_level),
    .o_rise     (w_rise)
  );

  assign w_sel   = (wAddress[31:4] == BASE_ADDRESS[31:4]);
  assign w_bmask = {{8{wByteEnable[3]}}, {8{wByteEnable[2]}},
                    {8{wByteEnable[1]}}, {8{wByteEnable[0]}}};
  assign w_wr    = '{wr: wWriteEnable & w_sel, ofs: wAddress[3:2],
                     bmask: w_bmask, data: wWriteData};

  assign w_lane_mask = w_wr.bmask[NI-1:0];
  assign w_edge_clr  = (w_wr.wr && w_wr.ofs == OFS_EDGE) ?
                       (w_wr.data[NI-1:0] & w_lane_mask) : '0;
  assign w_mask_we   = w_wr.wr && (w_wr.ofs == OFS_MASK);
  assign w_cnt_clr   = w_wr.wr && (w_wr.ofs == OFS_COUNT);
  assign w_any_rise  = |w_rise;

  // A new rising edge beats a same-cycle W1C, and a COUNT clear still counts this cycle's event.
  always_ff @(posedge core_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_edge  <= '0;
      r_mask  <= '0;
      r_count <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      if (w_mask_we)
        r_mask <= (r_mask & ~w_lane_mask) | (w_wr.data[NI-1:0] & w_lane_mask);
      if (w_cnt_clr)       r_count <= {31'd0, w_any_rise};
      else if (w_any_rise) r_count <= r_count + 32'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (wAddress[3:2])
      OFS_STATE: w_rdata = 32'(w_level);
      OFS_EDGE:  w_rdata = 32'(r_edge);
      OFS_MASK:  w_rdata = 32'(r_mask);
      OFS_COUNT: w_rdata = r_count;
      default:   w_rdata = '0;
    endcase
  end

  assign wReadData = (wReadEnable && w_sel) ? w_rdata : 32'hz;
  assign irq       = |(r_edge & r_mask);
  assign w_unused  = ^{wAddress[1:0], w_wr.data, w_wr.bmask};
endmodule
